// File: rtl/pipelined_multiply_add_if.sv
// Operand/result bundle for the pipelined multiply-add: operand set in, tagged product out.
interface pipelined_multiply_add_if #(
    parameter int unsigned quotient_width = 16,
    parameter int unsigned divisor_width  = 8
);
    localparam int unsigned tag_width     = 8;
    localparam int unsigned product_width = quotient_width + divisor_width;

    logic                      input_valid;
    logic [tag_width-1:0]      tag;
    logic [quotient_width-1:0] quotient;
    logic [divisor_width-1:0]  divisor;
    logic [quotient_width-1:0] addend;
    logic                      output_valid;
    logic [tag_width-1:0]      tag_out;
    logic [product_width-1:0]  product;

    modport master (
        output input_valid, tag, quotient, divisor, addend,
        input  output_valid, tag_out, product
    );

    modport slave (
        input  input_valid, tag, quotient, divisor, addend,
        output output_valid, tag_out, product
    );
endinterface

// File: rtl/pipelined_multiply_add.sv
// Fully pipelined shift-add multiply-add: product = quotient * divisor + addend,
// signed quotient/addend, unsigned divisor, one operand set per clock, tag carried along.
module pipelined_multiply_add #(
    parameter int unsigned quotient_width = 16,
    parameter int unsigned divisor_width  = 8
) (
    input  logic                    clock,
    input  logic                    nreset,
    pipelined_multiply_add_if.slave bus
);
    localparam int unsigned tag_width     = 8;
    localparam int unsigned product_width = quotient_width + divisor_width;
    localparam int unsigned stages        = divisor_width + 1;

    logic [stages-1:0]         stage_valid;
    logic [stages-1:0]         stage_neg;
    logic [tag_width-1:0]      stage_tag     [stages];
    logic [quotient_width-1:0] stage_addend  [stages];
    logic [product_width-1:0]  stage_acc     [stages];
    // Magnitude and divisor are consumed by the add stages only, so they stop one stage early.
    logic [quotient_width-1:0] stage_mag     [divisor_width];
    logic [divisor_width-1:0]  stage_divisor [divisor_width];

    logic [quotient_width-1:0] mag_c;
    logic [product_width-1:0]  acc_next_c [divisor_width];
    logic [product_width-1:0]  signed_acc_c;
    logic [product_width-1:0]  product_c;

    // Two's-complement magnitude; the most negative quotient maps to 2^(qw-1) unsigned.
    assign mag_c = bus.quotient[quotient_width-1]
                 ? (~bus.quotient + quotient_width'(1))
                 : bus.quotient;

    // Add stage k consumes divisor bit (dw-k), MSB first.
    for (genvar k = 1; k <= divisor_width; k++) begin : g_add
        assign acc_next_c[k-1] = (stage_acc[k-1] << 1)
                               + (stage_divisor[k-1][divisor_width-k]
                                  ? product_width'(stage_mag[k-1])
                                  : product_width'(0));
    end

    assign signed_acc_c = stage_neg[stages-1]
                        ? (~stage_acc[stages-1] + product_width'(1))
                        : stage_acc[stages-1];

    assign product_c = signed_acc_c
                     + {{divisor_width{stage_addend[stages-1][quotient_width-1]}},
                        stage_addend[stages-1]};

    // Capture stage plus the divisor_width add stages.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            stage_valid <= '0;
            stage_neg   <= '0;
            for (int k = 0; k < stages; k++) begin
                stage_tag[k]    <= '0;
                stage_addend[k] <= '0;
                stage_acc[k]    <= '0;
            end
            for (int k = 0; k < divisor_width; k++) begin
                stage_mag[k]     <= '0;
                stage_divisor[k] <= '0;
            end
        end else begin
            stage_valid      <= {stage_valid[stages-2:0], bus.input_valid};
            stage_neg        <= {stage_neg[stages-2:0], bus.quotient[quotient_width-1]};
            stage_tag[0]     <= bus.tag;
            stage_addend[0]  <= bus.addend;
            stage_acc[0]     <= '0;
            stage_mag[0]     <= mag_c;
            stage_divisor[0] <= bus.divisor;
            for (int k = 1; k < stages; k++) begin
                stage_tag[k]    <= stage_tag[k-1];
                stage_addend[k] <= stage_addend[k-1];
                stage_acc[k]    <= acc_next_c[k-1];
            end
            for (int k = 1; k < divisor_width; k++) begin
                stage_mag[k]     <= stage_mag[k-1];
                stage_divisor[k] <= stage_divisor[k-1];
            end
        end
    end

    // Output stage: data only updates for valid sets, so it holds across bubbles.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            bus.output_valid <= 1'b0;
            bus.tag_out      <= '0;
            bus.product      <= '0;
        end else begin
            bus.output_valid <= stage_valid[stages-1];
            if (stage_valid[stages-1]) begin
                bus.tag_out <= stage_tag[stages-1];
                bus.product <= product_c;
            end
        end
    end
endmodule
